// File: rtl/pcu_pkg.sv
// Shared definitions for the program-counter unit: RAS sizing helpers and
// the next-PC source select used by the op-priority mux.
package pcu_pkg;

  // Pointer width into an N-entry circular stack; never narrower than 1 bit.
  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold an occupancy count of 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,  // pc + 1
    SEL_TGT = 2'd1,  // jump / call / taken-branch target
    SEL_RAS = 2'd2   // return address from top of stack
  } pc_sel_e;

endpackage

// File: rtl/pcu_ras.sv
// Return-address stack: LIFO over a circular buffer. A push while full
// overwrites the oldest entry so the newest DEPTH addresses always survive.
module pcu_ras
  import pcu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          top,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = ras_ptr_w(DEPTH);
  localparam int CNT_W = count_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  // Explicit wrap keeps the ring correct for non-power-of-two depths.
  assign ptr_inc = (top_ptr == LAST_IDX) ? '0 : top_ptr + 1'b1;
  assign ptr_dec = (top_ptr == '0) ? LAST_IDX : top_ptr - 1'b1;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign top   = empty ? '0 : mem[top_ptr];

  // NOTE: storage has no reset; count and pointer alone define validity, so
  // stale entries are unreachable and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_inc] <= data_in;
    end
  end

  // Push takes precedence; the owner never requests both in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_ptr <= LAST_IDX;
      count   <= '0;
    end else if (push) begin
      top_ptr <= ptr_inc;
      if (!full) begin
        count <= count + 1'b1;
      end
    end else if (pop && !empty) begin
      top_ptr <= ptr_dec;
      count   <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with an N-deep return-address stack and sticky
// over/underflow flags. Define PCU_REL_BRANCH_EN for PC-relative branches.
module pc_unit_ras
  import pcu_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               RAS_DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pc_en,
  input  logic                          jump,
  input  logic                          branch,
  input  logic                          cond,
  input  logic                          call,
  input  logic                          ret,
  input  logic [WIDTH-1:0]              imm,
  input  logic                          clr_flags,
  output logic [WIDTH-1:0]              pc,
  output logic [WIDTH-1:0]              pc_plus1,
  output logic [WIDTH-1:0]              ra_top,
  output logic [count_w(RAS_DEPTH)-1:0] ras_count,
  output logic                          ras_ovf,
  output logic                          ras_unf
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_next;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_full;
  logic             ras_empty;
  logic             ovf_set;
  logic             unf_set;

  assign pc_plus1 = pc + 1'b1;

  pcu_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ras_push),
    .pop     (ras_pop),
    .data_in (pc_plus1),
    .top     (ra_top),
    .count   (ras_count),
    .full    (ras_full),
    .empty   (ras_empty)
  );

  // Priority: ret > call > jump > taken branch > sequential. Everything is
  // gated by pc_en so a stall changes neither PC, stack nor flags.
  // NOTE: every output of this block gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    sel      = SEL_SEQ;
    target   = imm;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (pc_en) begin
      if (ret) begin
        if (ras_empty) begin
          unf_set = 1'b1;
        end else begin
          sel     = SEL_RAS;
          ras_pop = 1'b1;
        end
      end else if (call) begin
        sel      = SEL_TGT;
        ras_push = 1'b1;
        ovf_set  = ras_full;
      end else if (jump) begin
        sel = SEL_TGT;
      end else if (branch && cond) begin
        sel = SEL_TGT;
`ifdef PCU_REL_BRANCH_EN
        // imm is already WIDTH bits, so sign extension is the identity here.
        target = pc + imm;
`else
        target = imm;
`endif
      end
    end
  end

  always_comb begin
    case (sel)
      SEL_RAS: pc_next = ra_top;
      SEL_TGT: pc_next = target;
      default: pc_next = pc_plus1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_VECTOR;
    end else if (pc_en) begin
      pc <= pc_next;
    end
  end

  // A fresh error outranks a simultaneous clear of the same flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      if (ovf_set)        ras_ovf <= 1'b1;
      else if (clr_flags) ras_ovf <= 1'b0;
      if (unf_set)        ras_unf <= 1'b1;
      else if (clr_flags) ras_unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: vector table plus hand sequences for
// stack overflow/underflow and asynchronous reset.
module tb_pc_unit_ras;

  localparam int W = 16;
  localparam int D = 8;

  localparam logic [6:0] EN  = 7'b1000000;
  localparam logic [6:0] JMP = 7'b0100000;
  localparam logic [6:0] BR  = 7'b0010000;
  localparam logic [6:0] CND = 7'b0001000;
  localparam logic [6:0] CAL = 7'b0000100;
  localparam logic [6:0] RET = 7'b0000010;
  localparam logic [6:0] CLR = 7'b0000001;

`ifdef PCU_REL_BRANCH_EN
  localparam logic [W-1:0] BR_IMM = 16'hFFFE;
  localparam logic [W-1:0] BR_EXP = 16'd8;
`else
  localparam logic [W-1:0] BR_IMM = 16'd40;
  localparam logic [W-1:0] BR_EXP = 16'd40;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         pc_en, jump, branch, cond, call, ret, clr_flags;
  logic [W-1:0] imm;
  logic [W-1:0] pc, pc_plus1, ra_top;
  logic [3:0]   ras_count;
  logic         ras_ovf, ras_unf;

  always #5 clk = ~clk;

  pc_unit_ras #(.WIDTH(W), .RAS_DEPTH(D), .RESET_VECTOR('0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pc_en     (pc_en),
    .jump      (jump),
    .branch    (branch),
    .cond      (cond),
    .call      (call),
    .ret       (ret),
    .imm       (imm),
    .clr_flags (clr_flags),
    .pc        (pc),
    .pc_plus1  (pc_plus1),
    .ra_top    (ra_top),
    .ras_count (ras_count),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  typedef struct {
    string        name;
    logic [6:0]   ops;
    logic [W-1:0] imm;
    logic [W-1:0] pc;
    logic [W-1:0] ra;
    int           cnt;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic vec_t mk(input string name, input logic [6:0] ops, input logic [W-1:0] imm_v,
                              input logic [W-1:0] pc_v, input logic [W-1:0] ra_v, input int cnt_v,
                              input logic ovf_v, input logic unf_v);
    vec_t v;
    v.name = name; v.ops = ops; v.imm = imm_v; v.pc = pc_v; v.ra = ra_v;
    v.cnt = cnt_v; v.ovf = ovf_v; v.unf = unf_v;
    return v;
  endfunction

  task automatic compare_head();
    vec_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.name, ".pc"},       32'(pc),        32'(e.pc));
    check({e.name, ".pc_plus1"}, 32'(pc_plus1),  32'(W'(e.pc + 1'b1)));
    check({e.name, ".ra_top"},   32'(ra_top),    32'(e.ra));
    check({e.name, ".count"},    32'(ras_count), 32'(e.cnt));
    check({e.name, ".ovf"},      32'(ras_ovf),   32'(e.ovf));
    check({e.name, ".unf"},      32'(ras_unf),   32'(e.unf));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    {pc_en, jump, branch, cond, call, ret, clr_flags} = v.ops;
    imm = v.imm;
    sb.push_back(v);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    logic [W-1:0] pushed [9];
    logic [W-1:0] cur;
    logic [W-1:0] tgt;

    reset_n = 1'b0;
    {pc_en, jump, branch, cond, call, ret, clr_flags} = '0;
    imm = '0;

    // Sequential fetch, stall, single call/return.
    for (int i = 1; i <= 5; i++) vecs.push_back(mk($sformatf("seq%0d", i), EN, '0, W'(i), '0, 0, 0, 0));
    vecs.push_back(mk("stall",        7'b0,    '0,     16'd5,      '0,      0, 0, 0));
    vecs.push_back(mk("stall_jmp",    JMP|CAL, 16'd99, 16'd5,      '0,      0, 0, 0));
    vecs.push_back(mk("call22",       EN|CAL,  16'd22, 16'd22,     16'd6,   1, 0, 0));
    for (int i = 1; i <= 3; i++) vecs.push_back(mk($sformatf("idle%0d", i), EN, '0, W'(22 + i), 16'd6, 1, 0, 0));
    vecs.push_back(mk("ret6",         EN|RET,  '0,     16'd6,      '0,      0, 0, 0));
    // Nested calls.
    vecs.push_back(mk("jmp2",         EN|JMP,  16'd2,     16'd2,      '0,       0, 0, 0));
    vecs.push_back(mk("call1000",     EN|CAL,  16'h1000,  16'h1000,   16'd3,    1, 0, 0));
    vecs.push_back(mk("seq1001",      EN,      '0,        16'h1001,   16'd3,    1, 0, 0));
    vecs.push_back(mk("call015d",     EN|CAL,  16'h015D,  16'h015D,   16'h1002, 2, 0, 0));
    vecs.push_back(mk("ret1002",      EN|RET,  '0,        16'h1002,   16'd3,    1, 0, 0));
    vecs.push_back(mk("ret3",         EN|RET,  '0,        16'd3,      '0,       0, 0, 0));
    // Branches, priority and wrap.
    vecs.push_back(mk("jmp10a",       EN|JMP,        16'd10,   16'd10,   '0, 0, 0, 0));
    vecs.push_back(mk("br_not_taken", EN|BR,         16'd40,   16'd11,   '0, 0, 0, 0));
    vecs.push_back(mk("jmp10b",       EN|JMP,        16'd10,   16'd10,   '0, 0, 0, 0));
    vecs.push_back(mk("br_taken",     EN|BR|CND,     BR_IMM,   BR_EXP,   '0, 0, 0, 0));
    vecs.push_back(mk("jmp_over_br",  EN|JMP|BR|CND, 16'h0030, 16'h0030, '0, 0, 0, 0));
    vecs.push_back(mk("jmpffff",      EN|JMP,        16'hFFFF, 16'hFFFF, '0, 0, 0, 0));
    vecs.push_back(mk("wrap",         EN,            '0,       16'h0000, '0, 0, 0, 0));
    // Call+ret in one cycle, call over jump.
    vecs.push_back(mk("jmp6",         EN|JMP,     16'd6,    16'd6,    '0,    0, 0, 0));
    vecs.push_back(mk("call100",      EN|CAL,     16'd100,  16'd100,  16'd7, 1, 0, 0));
    vecs.push_back(mk("callret",      EN|CAL|RET, 16'd200,  16'd7,    '0,    0, 0, 0));
    vecs.push_back(mk("call_over_jmp",EN|CAL|JMP, 16'h0040, 16'h0040, 16'd8, 1, 0, 0));
    vecs.push_back(mk("ret8",         EN|RET,     '0,       16'd8,    '0,    0, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    check("reset.pc",    32'(pc),        32'h0);
    check("reset.count", 32'(ras_count), 32'h0);
    check("reset.ra",    32'(ra_top),    32'h0);
    check("reset.flags", 32'({ras_ovf, ras_unf}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Overflow: nine calls into an eight-entry stack, then drain and underflow.
    apply(mk("ovf_jmp", EN|JMP, 16'h0100, 16'h0100, '0, 0, 0, 0));
    cur = 16'h0100;
    for (int i = 0; i < 9; i++) begin
      pushed[i] = W'(cur + 1'b1);
      tgt       = W'(16'h0200 + 16 * i);
      apply(mk($sformatf("ovf_call%0d", i), EN|CAL, tgt, tgt, pushed[i],
               (i < D) ? i + 1 : D, (i == D), 0));
      cur = tgt;
    end
    for (int k = 0; k < 8; k++) begin
      apply(mk($sformatf("ovf_ret%0d", k), EN|RET, '0, pushed[8-k],
               (k < 7) ? pushed[7-k] : '0, 7 - k, 1, 0));
    end
    cur = W'(pushed[1] + 1'b1);
    apply(mk("unf_ret",  EN|RET,     '0, cur, '0, 0, 1, 1));
    apply(mk("clr_stall", CLR,       '0, cur, '0, 0, 0, 0));
    cur = W'(cur + 1'b1);
    apply(mk("err_wins", EN|RET|CLR, '0, cur, '0, 0, 0, 1));
    apply(mk("pre_rst_call", EN|CAL, 16'h0077, 16'h0077, W'(cur + 1'b1), 1, 0, 1));

    // Asynchronous reset in the middle of a cycle with a call pending.
    @(negedge clk);
    {pc_en, jump, branch, cond, call, ret, clr_flags} = EN|CAL;
    imm = 16'h0088;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst.pc",    32'(pc),        32'(16'h0000));
    check("async_rst.count", 32'(ras_count), 32'h0);
    check("async_rst.ra",    32'(ra_top),    32'h0);
    check("async_rst.ovf",   32'(ras_ovf),   32'h0);
    check("async_rst.unf",   32'(ras_unf),   32'h0);
    @(negedge clk);
    {pc_en, jump, branch, cond, call, ret, clr_flags} = '0;
    reset_n = 1'b1;
    apply(mk("post_rst_seq", EN, '0, 16'd1, '0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
